// File: rtl/vproc_pkg.sv
// Shared vproc types and constants used by the divide lane.
// Holds the lane FSM encoding, operand/result widths and a magnitude helper.
package vproc_pkg;

    localparam int unsigned DIV_LANE_OP_W  = 33;
    localparam int unsigned DIV_LANE_RES_W = 32;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_DONE
    } div_lane_state_e;

    // Magnitude of a 33-bit two's complement value; -2^32 maps to 2^32, which still fits unsigned.
    function automatic logic [DIV_LANE_OP_W-1:0] div_abs(input logic [DIV_LANE_OP_W-1:0] v);
        return v[DIV_LANE_OP_W-1] ? -v : v;
    endfunction

endpackage

// File: rtl/vproc_div_iter_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only when it does not borrow.
module vproc_div_iter_step
    import vproc_pkg::*;
(
    input  logic [DIV_LANE_OP_W:0]   i_rem,
    input  logic                     i_bit,
    input  logic [DIV_LANE_OP_W-1:0] i_divisor,
    output logic [DIV_LANE_OP_W:0]   o_rem,
    output logic                     o_q
);

    logic [DIV_LANE_OP_W:0]   w_shifted;
    logic [DIV_LANE_OP_W+1:0] w_diff;
    logic                     w_unused;

    // The partial remainder is always below the divisor, so its top bit stays clear.
    assign w_unused  = i_rem[DIV_LANE_OP_W];
    assign w_shifted = {i_rem[DIV_LANE_OP_W-1:0], i_bit};
    assign w_diff    = {1'b0, w_shifted} - {2'b00, i_divisor};
    assign o_q       = ~w_diff[DIV_LANE_OP_W+1];
    assign o_rem     = o_q ? w_diff[DIV_LANE_OP_W:0] : w_shifted;

endmodule

// File: rtl/vproc_div_iter_lane.sv
// Iterative restoring divide lane: 33-bit signed operands in, 32-bit quotient or remainder out.
// Optional macro VPROC_DIV_ZERO_FAST_EN: divide-by-zero skips the iteration and completes on accept.
module vproc_div_iter_lane
    import vproc_pkg::*;
#(
    parameter int unsigned BITS_PER_CYCLE = 1,
    parameter type         CTRL_T         = logic,
    parameter bit          DONT_CARE_ZERO = 1'b0
) (
    input  logic                      clk_i,
    input  logic                      async_rst_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  CTRL_T                     in_ctrl_i,
    input  logic                      in_rem_i,
    input  logic [DIV_LANE_OP_W-1:0]  in_op1_i,
    input  logic [DIV_LANE_OP_W-1:0]  in_op2_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output CTRL_T                     out_ctrl_o,
    output logic [DIV_LANE_RES_W-1:0] out_res_o,
    output logic                      busy_o
);

    localparam int unsigned N_ITER   = DIV_LANE_OP_W / BITS_PER_CYCLE;
    localparam logic [5:0]  CNT_LOAD = 6'(N_ITER - 1);

    if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 3 && BITS_PER_CYCLE != 11) begin : g_bad_bpc
        $error("vproc_div_iter_lane: BITS_PER_CYCLE must be 1, 3 or 11");
    end

    div_lane_state_e r_state, w_state_next, w_start_state;

    CTRL_T                     r_ctrl;
    logic                      r_rem_sel;
    logic                      r_neg_q;
    logic                      r_neg_r;
    logic                      r_div_zero;
    logic [5:0]                r_cnt;
    logic [DIV_LANE_OP_W-1:0]  r_dvd;
    logic [DIV_LANE_OP_W-1:0]  r_div;
    logic [DIV_LANE_OP_W:0]    r_prem;
    logic [DIV_LANE_RES_W-1:0] r_res;

    logic                                         w_accept;
    logic                                         w_last;
    logic                                         w_op2_zero;
    logic [BITS_PER_CYCLE:0][DIV_LANE_OP_W:0]     w_prem_chain;
    logic [BITS_PER_CYCLE-1:0]                    w_q_bits;
    logic [DIV_LANE_OP_W-1:0]                     w_dvd_next;
    logic [DIV_LANE_RES_W-1:0]                    w_res_q;
    logic [DIV_LANE_RES_W-1:0]                    w_res_r;
    logic [DIV_LANE_RES_W-1:0]                    w_res_dc;

    assign w_accept   = in_valid_i & in_ready_o;
    assign w_last     = (r_cnt == '0);
    assign w_op2_zero = (in_op2_i == '0);

`ifdef VPROC_DIV_ZERO_FAST_EN
    assign w_start_state = w_op2_zero ? DIV_DONE : DIV_CALC;
`else
    assign w_start_state = DIV_CALC;
`endif

    // Dividend bits are consumed MSB first; each quotient bit shifts into the vacated LSB.
    assign w_prem_chain[0] = r_prem;
    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
        vproc_div_iter_step u_step (
            .i_rem    (w_prem_chain[g]),
            .i_bit    (r_dvd[DIV_LANE_OP_W-1-g]),
            .i_divisor(r_div),
            .o_rem    (w_prem_chain[g+1]),
            .o_q      (w_q_bits[BITS_PER_CYCLE-1-g])
        );
    end
    assign w_dvd_next = (r_dvd << BITS_PER_CYCLE) | DIV_LANE_OP_W'(w_q_bits);

    // Divide-by-zero leaves an all-ones quotient, which must not be negated.
    assign w_res_q  = (r_neg_q & ~r_div_zero) ? -w_dvd_next[DIV_LANE_RES_W-1:0]
                                              :  w_dvd_next[DIV_LANE_RES_W-1:0];
    assign w_res_r  = r_neg_r ? -w_prem_chain[BITS_PER_CYCLE][DIV_LANE_RES_W-1:0]
                              :  w_prem_chain[BITS_PER_CYCLE][DIV_LANE_RES_W-1:0];
    assign w_res_dc = DONT_CARE_ZERO ? '0 : 'x;

    // NOTE: non-blocking assignments only in clocked processes so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: a default assignment up front keeps every path covered so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            DIV_IDLE: if (in_valid_i) w_state_next = w_start_state;
            DIV_CALC: if (w_last)     w_state_next = DIV_DONE;
            DIV_DONE: if (out_ready_i) w_state_next = in_valid_i ? w_start_state : DIV_IDLE;
            default:  w_state_next = DIV_IDLE;
        endcase
    end

    always_comb begin
        out_valid_o = (r_state == DIV_DONE);
        busy_o      = (r_state != DIV_IDLE);
        in_ready_o  = (r_state == DIV_IDLE) | ((r_state == DIV_DONE) & out_ready_i);
        out_ctrl_o  = r_ctrl;
        out_res_o   = (r_state == DIV_DONE) ? r_res : w_res_dc;
    end

    // NOTE: datapath registers carry no reset; the FSM alone decides when their contents are meaningful.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_ctrl     <= in_ctrl_i;
            r_rem_sel  <= in_rem_i;
            r_dvd      <= div_abs(in_op1_i);
            r_div      <= div_abs(in_op2_i);
            r_neg_q    <= in_op1_i[DIV_LANE_OP_W-1] ^ in_op2_i[DIV_LANE_OP_W-1];
            r_neg_r    <= in_op1_i[DIV_LANE_OP_W-1];
            r_div_zero <= w_op2_zero;
            r_cnt      <= CNT_LOAD;
            r_prem     <= '0;
`ifdef VPROC_DIV_ZERO_FAST_EN
            if (w_op2_zero) begin
                r_res <= in_rem_i ? in_op1_i[DIV_LANE_RES_W-1:0] : '1;
            end
`endif
        end else if (r_state == DIV_CALC) begin
            r_dvd  <= w_dvd_next;
            r_prem <= w_prem_chain[BITS_PER_CYCLE];
            r_cnt  <= r_cnt - 6'd1;
            if (w_last) begin
                r_res <= r_rem_sel ? w_res_r : w_res_q;
            end
        end
    end

endmodule

// File: tb/tb_vproc_div_iter_lane.sv
// Self-checking bench for vproc_div_iter_lane: directed vectors, an arithmetic reference model
// with a per-cycle compare process, latency/hold/reset checks. Honours VPROC_DIV_ZERO_FAST_EN.
module tb_vproc_div_iter_lane;

    localparam int unsigned BPC      = 1;
    localparam int          CALC_LAT = 33 / BPC + 1;
`ifdef VPROC_DIV_ZERO_FAST_EN
    localparam int          ZERO_LAT = 1;
`else
    localparam int          ZERO_LAT = CALC_LAT;
`endif

    typedef logic [7:0] ctrl_t;
    typedef struct packed {
        logic [31:0] res;
        ctrl_t       ctrl;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        async_rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    ctrl_t       in_ctrl_i;
    logic        in_rem_i;
    logic [32:0] in_op1_i;
    logic [32:0] in_op2_i;
    logic        out_valid_o;
    logic        out_ready_i;
    ctrl_t       out_ctrl_o;
    logic [31:0] out_res_o;
    logic        busy_o;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    vproc_div_iter_lane #(
        .BITS_PER_CYCLE(BPC),
        .CTRL_T        (ctrl_t),
        .DONT_CARE_ZERO(1'b1)
    ) dut (
        .clk_i      (clk_i),
        .async_rst_i(async_rst_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .in_ctrl_i  (in_ctrl_i),
        .in_rem_i   (in_rem_i),
        .in_op1_i   (in_op1_i),
        .in_op2_i   (in_op2_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_ctrl_o (out_ctrl_o),
        .out_res_o  (out_res_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: signed integer division with truncation toward zero; x/0 gives all ones, x%0 gives x.
    function automatic logic [31:0] model_res(input logic [32:0] a, input logic [32:0] b, input logic rem);
        longint      sa, sb, q, r;
        logic [63:0] sel;
        sa = {{31{a[32]}}, a};
        sb = {{31{b[32]}}, b};
        if (sb == 0) begin
            q = -1;
            r = sa;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        sel = rem ? r : q;
        return sel[31:0];
    endfunction

    always @(negedge clk_i) begin
        if (!async_rst_i && out_valid_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", out_valid_o, 1'b0);
            end else begin
                check("model_res", out_res_o, exp_q[0].res);
                check("model_ctrl", out_ctrl_o, exp_q[0].ctrl);
            end
        end
    end

    always @(posedge clk_i) begin
        if (!async_rst_i && out_valid_o && out_ready_i && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end
    end

    // Called at a negedge; returns at the negedge of cycle 1 after the accept edge.
    task automatic issue(input logic [32:0] op1, input logic [32:0] op2, input logic rem, input ctrl_t ctrl);
        int guard;
        in_op1_i   = op1;
        in_op2_i   = op2;
        in_rem_i   = rem;
        in_ctrl_i  = ctrl;
        in_valid_i = 1'b1;
        guard      = 0;
        while (!in_ready_o && guard < 100) begin
            @(negedge clk_i);
            guard++;
        end
        if (guard >= 100) check("ready_timeout", in_ready_o, 1'b1);
        @(posedge clk_i);
        exp_q.push_back('{res: model_res(op1, op2, rem), ctrl: ctrl});
        @(negedge clk_i);
        in_valid_i = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid_o && lat < 300) begin
            @(negedge clk_i);
            lat++;
        end
    endtask

    task automatic run_one(input string name, input logic [32:0] op1, input logic [32:0] op2,
                           input logic rem, input ctrl_t ctrl, input logic [31:0] lit, input int exp_lat);
        int lat;
        issue(op1, op2, rem, ctrl);
        wait_valid(lat);
        check({name, "_lat"}, lat, exp_lat);
        check({name, "_lit"}, out_res_o, lit);
        check({name, "_busy"}, busy_o, 1'b1);
        @(negedge clk_i);
        check({name, "_idle"}, out_valid_o, 1'b0);
    endtask

    initial begin
        int lat;
        async_rst_i = 1'b1;
        in_valid_i  = 1'b0;
        in_ctrl_i   = '0;
        in_rem_i    = 1'b0;
        in_op1_i    = '0;
        in_op2_i    = '0;
        out_ready_i = 1'b1;

        check("pin_model_q",   model_res(33'd100, 33'd7, 1'b0), 32'h0000_000E);
        check("pin_model_r",   model_res(33'h1_FFFF_FFF9, 33'd2, 1'b1), 32'hFFFF_FFFF);
        check("pin_model_ovf", model_res(33'h1_8000_0000, 33'h1_FFFF_FFFF, 1'b0), 32'h8000_0000);
        check("pin_model_dz",  model_res(33'h0_0000_1234, 33'd0, 1'b1), 32'h0000_1234);

        #12;
        check("rst_valid", out_valid_o, 1'b0);
        check("rst_busy",  busy_o,      1'b0);
        check("rst_ready", in_ready_o,  1'b1);
        @(negedge clk_i);
        async_rst_i = 1'b0;
        @(negedge clk_i);
        check("post_rst_ready", in_ready_o, 1'b1);
        check("post_rst_busy",  busy_o,     1'b0);

        run_one("q_100_7",   33'd100,         33'd7,           1'b0, 8'h11, 32'h0000_000E, CALC_LAT);
        run_one("r_100_7",   33'd100,         33'd7,           1'b1, 8'h12, 32'h0000_0002, CALC_LAT);
        run_one("q_m7_2",    33'h1_FFFF_FFF9, 33'd2,           1'b0, 8'h21, 32'hFFFF_FFFD, CALC_LAT);
        run_one("r_m7_2",    33'h1_FFFF_FFF9, 33'd2,           1'b1, 8'h22, 32'hFFFF_FFFF, CALC_LAT);
        run_one("q_7_m2",    33'd7,           33'h1_FFFF_FFFE, 1'b0, 8'h23, 32'hFFFF_FFFD, CALC_LAT);
        run_one("r_7_m2",    33'd7,           33'h1_FFFF_FFFE, 1'b1, 8'h24, 32'h0000_0001, CALC_LAT);
        run_one("q_dz",      33'h0_0000_1234, 33'd0,           1'b0, 8'h31, 32'hFFFF_FFFF, ZERO_LAT);
        run_one("r_dz",      33'h0_0000_1234, 33'd0,           1'b1, 8'h32, 32'h0000_1234, ZERO_LAT);
        run_one("q_dz_neg",  33'h1_FFFF_FF9C, 33'd0,           1'b0, 8'h33, 32'hFFFF_FFFF, ZERO_LAT);
        run_one("r_dz_neg",  33'h1_FFFF_FF9C, 33'd0,           1'b1, 8'h34, 32'hFFFF_FF9C, ZERO_LAT);
        run_one("q_ovf",     33'h1_8000_0000, 33'h1_FFFF_FFFF, 1'b0, 8'h41, 32'h8000_0000, CALC_LAT);
        run_one("r_ovf",     33'h1_8000_0000, 33'h1_FFFF_FFFF, 1'b1, 8'h42, 32'h0000_0000, CALC_LAT);
        run_one("q_unsig",   33'h0_FFFF_FFFF, 33'h0_0000_0010, 1'b0, 8'h51, 32'h0FFF_FFFF, CALC_LAT);
        run_one("r_unsig",   33'h0_FFFF_FFFF, 33'h0_0000_0010, 1'b1, 8'h52, 32'h0000_000F, CALC_LAT);
        run_one("q_max_1",   33'h0_7FFF_FFFF, 33'd1,           1'b0, 8'h53, 32'h7FFF_FFFF, CALC_LAT);

        // Back-pressure in DONE, then handshake and second accept on the same edge.
        out_ready_i = 1'b0;
        issue(33'd1000, 33'd9, 1'b0, 8'h61);
        wait_valid(lat);
        check("hold_a_lat", lat, CALC_LAT);
        in_op1_i   = 33'd1000;
        in_op2_i   = 33'h1_FFFF_FFFD;
        in_rem_i   = 1'b1;
        in_ctrl_i  = 8'h62;
        in_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", out_valid_o, 1'b1);
            check("hold_res",   out_res_o,   32'd111);
            check("hold_ctrl",  out_ctrl_o,  8'h61);
            check("hold_ready", in_ready_o,  1'b0);
            @(negedge clk_i);
        end
        out_ready_i = 1'b1;
        #1;
        check("release_ready", in_ready_o, 1'b1);
        @(posedge clk_i);
        exp_q.push_back('{res: model_res(33'd1000, 33'h1_FFFF_FFFD, 1'b1), ctrl: 8'h62});
        @(negedge clk_i);
        in_valid_i = 1'b0;
        check("b2b_valid_low", out_valid_o, 1'b0);
        check("b2b_busy",      busy_o,      1'b1);
        wait_valid(lat);
        check("hold_b_lat", lat, CALC_LAT);
        check("hold_b_lit", out_res_o, 32'h0000_0001);
        @(negedge clk_i);

        // Reset in CALC cycle 10 discards the transaction.
        issue(33'd5000, 33'd3, 1'b0, 8'h71);
        for (int i = 1; i < 10; i++) @(negedge clk_i);
        check("pre_rst_busy", busy_o, 1'b1);
        #2;
        async_rst_i = 1'b1;
        #1;
        check("mid_rst_valid", out_valid_o, 1'b0);
        check("mid_rst_busy",  busy_o,      1'b0);
        check("mid_rst_ready", in_ready_o,  1'b1);
        exp_q.delete();
        @(negedge clk_i);
        async_rst_i = 1'b0;
        @(negedge clk_i);
        run_one("after_rst", 33'd5000, 33'd3, 1'b0, 8'h72, 32'h0000_0682, CALC_LAT);

        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
